seq_comb_calc: RTL and testbench

Parametrised, clocked successor to the board calculator. It performs signed W-bit two's-complement arithmetic and logic on registered operands. It adds a sequential shift-add multiplier, an accumulate mode that reuses the previous result, and a start/busy/done handshake. Overflow is reported per operation and as a sticky flag. It sits between the switch/key inputs and the sign-magnitude 7-segment display decoders, which consume `R`, `ovf` and `sticky_ovf`.

---
 rtl/seq_comb_calc_if.sv | 26 ++
 rtl/seq_comb_calc.sv | 147 ++++++++++++++
 tb/tb_seq_comb_calc.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_comb_calc_if.sv
// Operand/result bundle between the switch/key front end and the calculator core.
// The master drives the operation request; the slave returns status and result.
interface seq_comb_calc_if #(
   parameter int unsigned W = 4
);
   logic         start;
   logic [2:0]   OP;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         clr_sticky;
   logic         busy;
   logic         done;
   logic [W-1:0] R;
   logic         ovf;
   logic         sticky_ovf;

   modport master (
      output start, OP, A, B, clr_sticky,
      input  busy, done, R, ovf, sticky_ovf
   );

   modport slave (
      input  start, OP, A, B, clr_sticky,
      output busy, done, R, ovf, sticky_ovf
   );
endinterface

// File: rtl/seq_comb_calc.sv
// Clocked signed W-bit calculator: single-cycle ALU ops plus a W-cycle shift-add multiplier,
// accumulate mode, per-op and sticky overflow.
module seq_comb_calc #(
   parameter int unsigned W = 4
) (
   input logic          CLOCK_50,
   input logic          RESET,
   seq_comb_calc_if.slave bus
);
   localparam int unsigned CntW = $clog2(W);

   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   r_q, r_d;
   logic           ovf_q, ovf_d;
   logic           done_q, done_d;
   logic           sticky_q, sticky_d;
   logic [2*W-1:0] mcand_q, mcand_d;
   logic [2*W-1:0] prod_q, prod_d;
   logic [W-1:0]   mplier_q, mplier_d;
   logic           neg_q, neg_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [W:0]     a_x, b_x, r_x, sum_x;
   logic [W-1:0]   alu_r, abs_a, abs_b;
   logic           alu_ovf, mul_ovf;
   logic [2*W-1:0] prod_last, prod_signed;

   // Arithmetic is done one bit wider so overflow is a disagreement of the top two bits.
   always_comb begin
      a_x     = {bus.A[W-1], bus.A};
      b_x     = {bus.B[W-1], bus.B};
      r_x     = {r_q[W-1], r_q};
      sum_x   = '0;
      alu_r   = '0;
      alu_ovf = 1'b0;
      case (bus.OP)
         3'b000:  sum_x = a_x + b_x;
         3'b001:  sum_x = a_x - b_x;
         3'b011:  sum_x = '0 - a_x;
         3'b111:  sum_x = r_x + a_x;
         default: sum_x = '0;
      endcase
      case (bus.OP)
         3'b100:  alu_r = bus.A & bus.B;
         3'b101:  alu_r = bus.A | bus.B;
         3'b110:  alu_r = bus.A ^ bus.B;
         default: begin
            alu_r   = sum_x[W-1:0];
            alu_ovf = sum_x[W] ^ sum_x[W-1];
         end
      endcase
      abs_a = bus.A[W-1] ? (~bus.A + 1'b1) : bus.A;
      abs_b = bus.B[W-1] ? (~bus.B + 1'b1) : bus.B;
   end

   // Final iteration result, signed, and range check on the upper W+1 bits.
   always_comb begin
      prod_last   = prod_q + (mplier_q[0] ? mcand_q : '0);
      prod_signed = neg_q ? (~prod_last + 1'b1) : prod_last;
      mul_ovf     = !((&prod_signed[2*W-1:W-1]) || !(|prod_signed[2*W-1:W-1]));
   end

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (bus.OP == 3'b010) begin
                  mcand_d  = {{W{1'b0}}, abs_a};
                  mplier_d = abs_b;
                  prod_d   = '0;
                  neg_d    = bus.A[W-1] ^ bus.B[W-1];
                  cnt_d    = '0;
                  state_d  = StMul;
               end else begin
                  r_d    = alu_r;
                  ovf_d  = alu_ovf;
                  done_d = 1'b1;
               end
            end
         end
         StMul: begin
            prod_d   = prod_last;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CntW'(W - 1)) begin
               r_d     = prod_signed[W-1:0];
               ovf_d   = mul_ovf;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // A completing overflow beats a simultaneous clear.
      if (done_d && ovf_d) begin
         sticky_d = 1'b1;
      end else if (bus.clr_sticky) begin
         sticky_d = 1'b0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state_q  <= StIdle;
         r_q      <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         sticky_q <= 1'b0;
         mcand_q  <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         r_q      <= r_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
         sticky_q <= sticky_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.busy       = (state_q == StMul);
   assign bus.done       = done_q;
   assign bus.R          = r_q;
   assign bus.ovf        = ovf_q;
   assign bus.sticky_ovf = sticky_q;
endmodule

// File: tb/tb_seq_comb_calc.sv
// Scoreboard bench for seq_comb_calc at W=4: expected results queued on issue, popped on done.
module tb_seq_comb_calc;
   localparam int unsigned W = 4;

   typedef struct packed {
      logic [3:0] r;
      logic       ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_comb_calc_if #(.W(W)) bus ();
   seq_comb_calc #(.W(W)) dut (.CLOCK_50(clk), .RESET(rst), .bus(bus));

   exp_t       sb[$];
   logic [3:0] r_model;
   int         n_checks = 0;
   int         n_fail = 0;

   // Exact integer arithmetic, then truncation and range test.
   function automatic exp_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                  input logic [3:0] rprev);
      int   sa, sb2, sr, ex;
      exp_t e;
      sa  = int'($signed(a));
      sb2 = int'($signed(b));
      sr  = int'($signed(rprev));
      e.ovf = 1'b0;
      case (op)
         3'd0:    ex = sa + sb2;
         3'd1:    ex = sa - sb2;
         3'd2:    ex = sa * sb2;
         3'd3:    ex = -sa;
         3'd7:    ex = sr + sa;
         default: ex = 0;
      endcase
      if (op == 3'd4) e.r = a & b;
      else if (op == 3'd5) e.r = a | b;
      else if (op == 3'd6) e.r = a ^ b;
      else begin
         e.r   = ex[3:0];
         e.ovf = (ex < -8) || (ex > 7);
      end
      return e;
   endfunction

   // Drive a request at a negedge and queue its expected result.
   task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      bus.start = 1'b1;
      bus.OP    = op;
      bus.A     = a;
      bus.B     = b;
      e = model(op, a, b, r_model);
      sb.push_back(e);
      r_model = e.r;
   endtask

   task automatic wait_done(input int budget, output int cycles, output bit seen);
      cycles = 0;
      while (!bus.done && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      seen = bus.done;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         output exp_t got, output exp_t want, output bit seen, output int cycles);
      issue(op, a, b);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(40, cycles, seen);
      got = {bus.R, bus.ovf};
      if (sb.size() > 0) want = sb.pop_front();
      else want = 'x;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({bus.busy, bus.done, bus.R, bus.ovf, bus.sticky_ovf} !== 8'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got busy/done/R/ovf/sticky %b/%b/%h/%b/%b required all 0",
                  bus.busy, bus.done, bus.R, bus.ovf, bus.sticky_ovf);
      end
   endtask

   task automatic test_add_sub();
      exp_t got, want;
      bit   seen;
      int   cyc;
      run_op(3'd0, 4'd7, 4'd1, got, want, seen, cyc);
      n_checks++;
      if (!seen || cyc != 0 || got !== want || got.r !== 4'b1000 || got.ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL add_7_1 got R=%b ovf=%b lat=%0d required R=%b ovf=%b lat=0",
                  got.r, got.ovf, cyc, want.r, want.ovf);
      end
      n_checks++;
      if (bus.sticky_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL add_sticky got %b required 1", bus.sticky_ovf);
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_one_cycle got %b required 0", bus.done);
      end
      run_op(3'd1, 4'b1000, 4'd1, got, want, seen, cyc);
      n_checks++;
      if (!seen || got !== want || got.r !== 4'b0111 || got.ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_m8_1 got R=%b ovf=%b required R=%b ovf=%b",
                  got.r, got.ovf, want.r, want.ovf);
      end
   endtask

   task automatic test_mul();
      exp_t want;
      int   cyc;
      issue(3'd2, 4'd3, 4'b1110);
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_busy_rise got busy=%b done=%b required 1/0", bus.busy, bus.done);
      end
      // A request while busy must be dropped, not queued.
      @(negedge clk);
      bus.start = 1'b1;
      bus.OP    = 3'd0;
      bus.A     = 4'd1;
      bus.B     = 4'd1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 2;
      while (!bus.done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      want = sb.pop_front();
      n_checks++;
      if (cyc != 4 || bus.R !== want.r || bus.ovf !== want.ovf || bus.R !== 4'b1010) begin
         n_fail++;
         $display("FAIL mul_3_m2 got R=%b ovf=%b lat=%0d required R=%b ovf=%b lat=4",
                  bus.R, bus.ovf, cyc, want.r, want.ovf);
      end
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_busy_fall got %b required 0", bus.busy);
      end
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.R !== 4'b1010) begin
         n_fail++;
         $display("FAIL mul_ignored_start got done=%b R=%b required done=0 R=1010",
                  bus.done, bus.R);
      end
   endtask

   task automatic test_mul_neg_edges();
      exp_t got, want;
      bit   seen;
      int   cyc;
      logic [2:0] ops[4] = '{3'd2, 3'd2, 3'd3, 3'd3};
      logic [3:0] as[4]  = '{4'b1000, 4'b1000, 4'b1000, 4'd3};
      logic [3:0] bs[4]  = '{4'b1111, 4'd1, 4'd0, 4'd0};
      logic [4:0] req[4] = '{5'b1000_1, 5'b1000_0, 5'b1000_1, 5'b1101_0};
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], got, want, seen, cyc);
         n_checks++;
         if (!seen || got !== want || got !== req[i]) begin
            n_fail++;
            $display("FAIL edge_op%0d op=%0d got R=%b ovf=%b required R=%b ovf=%b",
                     i, ops[i], got.r, got.ovf, want.r, want.ovf);
         end
      end
   endtask

   task automatic test_acc_logic();
      exp_t got, want;
      bit   seen;
      int   cyc;
      logic [2:0] ops[4] = '{3'd0, 3'd7, 3'd7, 3'd4};
      logic [3:0] as[4]  = '{4'd2, 4'd2, 4'd1, 4'b1100};
      logic [3:0] bs[4]  = '{4'd3, 4'd0, 4'd0, 4'b1010};
      logic [4:0] req[4] = '{5'b0101_0, 5'b0111_0, 5'b1000_1, 5'b1000_0};
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], bs[i], got, want, seen, cyc);
         n_checks++;
         if (!seen || got !== want || got !== req[i]) begin
            n_fail++;
            $display("FAIL acc_seq%0d op=%0d got R=%b ovf=%b required R=%b ovf=%b",
                     i, ops[i], got.r, got.ovf, want.r, want.ovf);
         end
      end
   endtask

   task automatic test_sticky();
      exp_t want;
      bus.clr_sticky = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.sticky_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL sticky_clear got %b required 0", bus.sticky_ovf);
      end
      issue(3'd0, 4'd7, 4'd1);
      @(negedge clk);
      bus.start      = 1'b0;
      bus.clr_sticky = 1'b0;
      want = sb.pop_front();
      n_checks++;
      if (bus.sticky_ovf !== 1'b1 || bus.done !== 1'b1 || bus.ovf !== want.ovf) begin
         n_fail++;
         $display("FAIL sticky_set_wins got sticky=%b done=%b ovf=%b required 1/1/%b",
                  bus.sticky_ovf, bus.done, bus.ovf, want.ovf);
      end
   endtask

   task automatic test_back_to_back();
      exp_t want;
      logic [2:0] ops[3] = '{3'd6, 3'd5, 3'd1};
      logic [3:0] as[3]  = '{4'd5, 4'b1001, 4'd2};
      logic [3:0] bs[3]  = '{4'd3, 4'd4, 4'd1};
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], as[i], bs[i]);
         @(negedge clk);
         want = sb.pop_front();
         n_checks++;
         if (bus.done !== 1'b1 || bus.R !== want.r || bus.ovf !== want.ovf) begin
            n_fail++;
            $display("FAIL b2b_%0d got done=%b R=%b ovf=%b required 1/%b/%b",
                     i, bus.done, bus.R, bus.ovf, want.r, want.ovf);
         end
      end
      bus.start = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_done_drop got %b required 0", bus.done);
      end
   endtask

   task automatic test_reset_mid_mul();
      exp_t got, want;
      bit   seen;
      int   cyc;
      issue(3'd2, 4'd3, 4'd3);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.R, bus.ovf, bus.sticky_ovf} !== 8'b0) begin
         n_fail++;
         $display("FAIL async_reset got busy/done/R/ovf/sticky %b/%b/%h/%b/%b required all 0",
                  bus.busy, bus.done, bus.R, bus.ovf, bus.sticky_ovf);
      end
      sb.delete();
      r_model = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(3'd0, 4'd1, 4'd1, got, want, seen, cyc);
      n_checks++;
      if (!seen || got !== want || got.r !== 4'd2) begin
         n_fail++;
         $display("FAIL post_reset_add got R=%b ovf=%b required R=%b ovf=%b",
                  got.r, got.ovf, want.r, want.ovf);
      end
   endtask

   initial begin
      rst            = 1'b0;
      bus.start      = 1'b0;
      bus.OP         = '0;
      bus.A          = '0;
      bus.B          = '0;
      bus.clr_sticky = 1'b0;
      r_model        = '0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_add_sub();
      test_mul();
      test_mul_neg_edges();
      test_acc_logic();
      test_sticky();
      test_back_to_back();
      test_reset_mid_mul();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
